// File: rtl/octave_ctrl.sv
// Octave index selector: synchronised up/down buttons step oct_sel with
// optional wrap, hold-to-auto-repeat, a change strobe and limit flags.
module octave_ctrl #(
  parameter  int NUM_OCT       = 4,
  parameter  int RESET_OCT     = 0,
  parameter  int WRAP          = 1,
  parameter  int REPEAT_EN     = 1,
  parameter  int HOLD_CYCLES   = 16,
  parameter  int REPEAT_CYCLES = 8,
  localparam int W             = (NUM_OCT > 2) ? $clog2(NUM_OCT) : 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         oct_up,
  input  logic         oct_down,
  output logic [W-1:0] oct_sel,
  output logic         oct_changed,
  output logic         at_min,
  output logic         at_max
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [W-1:0]  TOP      = W'(NUM_OCT - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LIM  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  logic [1:0]    up_sync_q, dn_sync_q;
  logic          up_prev_q, dn_prev_q;
  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sel_q, sel_d;
  logic          changed_q;

  logic up_s2, dn_s2, rise_up, rise_dn;
  logic do_step, step_dir, held_lost;

  assign up_s2   = up_sync_q[1];
  assign dn_s2   = dn_sync_q[1];
  assign rise_up = up_s2 & ~up_prev_q;
  assign rise_dn = dn_s2 & ~dn_prev_q;

  // Repeat is abandoned when the held button drops or the other one joins.
  assign held_lost = dir_q ? (~up_s2 | dn_s2) : (~dn_s2 | up_s2);

  function automatic logic [W-1:0] next_oct(input logic [W-1:0] cur, input logic up);
    if (up) begin
      if (cur == TOP) return (WRAP != 0) ? '0 : cur;
      return cur + 1'b1;
    end
    if (cur == '0) return (WRAP != 0) ? TOP : cur;
    return cur - 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    do_step  = 1'b0;
    step_dir = dir_q;
    unique case (state_q)
      IDLE: begin
        if ((rise_up ^ rise_dn) && !(up_s2 && dn_s2)) begin
          do_step  = 1'b1;
          step_dir = rise_up;
          dir_d    = rise_up;
          cnt_d    = '0;
          state_d  = HOLD;
        end
      end
      HOLD, RPT: begin
        if (held_lost) begin
          state_d = IDLE;
        end else if (REPEAT_EN != 0) begin
          if (cnt_q == ((state_q == HOLD) ? HOLD_LIM : RPT_LIM)) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = RPT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d = do_step ? next_oct(sel_q, step_dir) : sel_q;
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= W'(RESET_OCT);
      changed_q <= 1'b0;
    end else begin
      up_sync_q <= {up_sync_q[0], oct_up};
      dn_sync_q <= {dn_sync_q[0], oct_down};
      up_prev_q <= up_s2;
      dn_prev_q <= dn_s2;
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      // Saturated steps leave sel unchanged and so raise no strobe.
      changed_q <= (sel_d != sel_q);
    end
  end

  assign oct_sel     = sel_q;
  assign oct_changed = changed_q;
  assign at_min      = (sel_q == '0);
  assign at_max      = (sel_q == TOP);

endmodule

// File: tb/tb_octave_ctrl.sv
// Bench for octave_ctrl: a wrapping 4-octave instance and a saturating
// 8-octave instance, each with a queue of expected change pulses.
module tb_octave_ctrl;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_w = 1'b1, rst_s = 1'b1;
  logic       up_w = 1'b0, dn_w = 1'b0, up_s = 1'b0, dn_s = 1'b0;
  logic [1:0] sel_w;
  logic [2:0] sel_s;
  logic       chg_w, chg_s, min_w, min_s, max_w, max_s;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_w[$];
  exp_t q_s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  octave_ctrl #(.NUM_OCT(4), .RESET_OCT(2), .WRAP(1), .REPEAT_EN(1),
                .HOLD_CYCLES(16), .REPEAT_CYCLES(8)) dut_w (
    .clk(clk), .nrst(rst_w), .oct_up(up_w), .oct_down(dn_w),
    .oct_sel(sel_w), .oct_changed(chg_w), .at_min(min_w), .at_max(max_w));

  octave_ctrl #(.NUM_OCT(8), .RESET_OCT(0), .WRAP(0), .REPEAT_EN(1),
                .HOLD_CYCLES(16), .REPEAT_CYCLES(8)) dut_s (
    .clk(clk), .nrst(rst_s), .oct_up(up_s), .oct_down(dn_s),
    .oct_sel(sel_s), .oct_changed(chg_s), .at_min(min_s), .at_max(max_s));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_w && chg_w) begin
      if (q_w.size() == 0) begin
        check("w_spurious_pulse", int'(chg_w), 0);
      end else begin
        e = q_w.pop_front();
        check("w_step_cycle", cyc, e.cyc);
        check("w_step_sel", int'(sel_w), e.val);
        check("w_at_min", int'(min_w), int'(e.val == 0));
        check("w_at_max", int'(max_w), int'(e.val == 3));
        $display("w: step to %0d at cycle %0d", sel_w, cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_s && chg_s) begin
      if (q_s.size() == 0) begin
        check("s_spurious_pulse", int'(chg_s), 0);
      end else begin
        e = q_s.pop_front();
        check("s_step_cycle", cyc, e.cyc);
        check("s_step_sel", int'(sel_s), e.val);
        check("s_at_min", int'(min_s), int'(e.val == 0));
        check("s_at_max", int'(max_s), int'(e.val == 7));
        $display("s: step to %0d at cycle %0d", sel_s, cyc);
      end
    end
  end

  // Press one button for len cycles; exp_val < 0 means no change is expected.
  // Driven at a negedge with counter value N, the step lands on cycle N+3.
  task automatic tap(input bit inst_s, input bit up, input int len, input int exp_val);
    exp_t e;
    @(negedge clk);
    if (exp_val >= 0) begin
      e.cyc = cyc + 3;
      e.val = exp_val;
      if (inst_s) q_s.push_back(e); else q_w.push_back(e);
    end
    if (inst_s) begin if (up) up_s = 1'b1; else dn_s = 1'b1; end
    else        begin if (up) up_w = 1'b1; else dn_w = 1'b1; end
    repeat (len) @(negedge clk);
    up_w = 1'b0; dn_w = 1'b0; up_s = 1'b0; dn_s = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic expect_at(input bit inst_s, input int at_cyc, input int val);
    exp_t e;
    e.cyc = at_cyc;
    e.val = val;
    if (inst_s) q_s.push_back(e); else q_w.push_back(e);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("w_reset_sel", int'(sel_w), 2);
    check("w_reset_chg", int'(chg_w), 0);
    check("w_reset_min", int'(min_w), 0);
    check("w_reset_max", int'(max_w), 0);
    check("s_reset_sel", int'(sel_s), 0);
    check("s_reset_min", int'(min_s), 1);
    rst_w = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge clk);

    // single steps and wrap at both ends
    tap(1'b0, 1'b1, 3, 3);
    tap(1'b0, 1'b1, 3, 0);
    tap(1'b0, 1'b0, 3, 3);

    // simultaneous rise: no step, and releasing down leaves up unarmed
    @(negedge clk);
    up_w = 1'b1; dn_w = 1'b1;
    repeat (5) @(negedge clk);
    dn_w = 1'b0;
    repeat (30) @(negedge clk);
    up_w = 1'b0;
    repeat (6) @(negedge clk);
    check("w_both_no_step", int'(sel_w), 3);

    // hold down into repeat, then reset with the button still held
    @(negedge clk);
    n = cyc;
    expect_at(1'b0, n + 3, 2);
    expect_at(1'b0, n + 19, 1);
    expect_at(1'b0, n + 27, 0);
    dn_w = 1'b1;
    repeat (30) @(negedge clk);
    check("w_repeat_done", q_w.size(), 0);
    rst_w = 1'b1;
    repeat (2) @(negedge clk);
    check("w_midrpt_rst_sel", int'(sel_w), 2);
    check("w_midrpt_rst_chg", int'(chg_w), 0);
    // the synchroniser restarts from 0, so the held button shows one fresh rise
    n = cyc;
    expect_at(1'b0, n + 3, 1);
    rst_w = 1'b0;
    repeat (5) @(negedge clk);
    dn_w = 1'b0;
    repeat (6) @(negedge clk);
    check("w_post_rst_sel", int'(sel_w), 1);
    tap(1'b0, 1'b0, 3, 0);

    // auto-repeat on the 8-octave instance
    @(negedge clk);
    n = cyc;
    expect_at(1'b1, n + 3, 1);
    expect_at(1'b1, n + 19, 2);
    expect_at(1'b1, n + 27, 3);
    expect_at(1'b1, n + 35, 4);
    expect_at(1'b1, n + 43, 5);
    expect_at(1'b1, n + 51, 6);
    up_s = 1'b1;
    repeat (52) @(negedge clk);
    up_s = 1'b0;
    repeat (10) @(negedge clk);
    check("s_repeat_final", int'(sel_s), 6);

    // saturation at both ends
    tap(1'b1, 1'b1, 3, 7);
    tap(1'b1, 1'b1, 3, -1);
    check("s_sat_top", int'(sel_s), 7);
    for (int k = 6; k >= 0; k--) tap(1'b1, 1'b0, 3, k);
    tap(1'b1, 1'b0, 3, -1);
    check("s_sat_bottom", int'(sel_s), 0);

    repeat (5) @(negedge clk);
    check("w_pending", q_w.size(), 0);
    check("s_pending", q_s.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
